// File: rtl/q88_pkg.sv
// Shared Q8.8 fixed-point constants and types for the neuron MAC and the sigmoid stage.
package q88_pkg;

  localparam int          Q_FRAC = 8;
  localparam logic [15:0] Q_ONE  = 16'h0100;
  localparam logic [15:0] Q_MAX  = 16'h7FFF;
  localparam logic [15:0] Q_MIN  = 16'h8000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } mac_state_t;

endpackage

// File: rtl/q88_sat_narrow.sv
// Narrows a wide signed Q.16 accumulator to Q8.8: arithmetic shift by Q_FRAC,
// then clip to the 16-bit signed range and flag the clip.
module q88_sat_narrow
  import q88_pkg::*;
#(
  parameter int IN_W = 34
) (
  input  logic signed [IN_W-1:0] acc,
  output logic [15:0]            z,
  output logic                   z_sat
);

  logic signed [IN_W-1:0] t_s;
  logic [IN_W-16:0]       hi_s;

  // The value fits in 16 bits exactly when every bit above bit 15 matches the sign.
  always_comb begin
    t_s  = acc >>> Q_FRAC;
    hi_s = t_s[IN_W-1:15];
    if ((&hi_s) || (~|hi_s)) begin
      z     = t_s[15:0];
      z_sat = 1'b0;
    end else if (t_s[IN_W-1]) begin
      z     = Q_MIN;
      z_sat = 1'b1;
    end else begin
      z     = Q_MAX;
      z_sat = 1'b1;
    end
  end

endmodule

// File: rtl/neuron_preact_mac.sv
// Neuron pre-activation: z = bias + sum(x_i * w_i) over N_INPUTS streamed Q8.8 pairs,
// saturated to Q8.8 and offered on a valid/ready port.
module neuron_preact_mac
  import q88_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int ACC_W    = 32 + $clog2(N_INPUTS) + 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bias_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x_in,
  input  logic [15:0] w_in,
  output logic        z_valid,
  input  logic        z_ready,
  output logic [15:0] z,
  output logic        z_sat,
  output logic        busy
);

  localparam int             CNT_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

  mac_state_t               state_r;
  mac_state_t               next_state_s;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  acc_sum_s;
  logic [CNT_W-1:0]         cnt_r;
  logic [15:0]              z_r;
  logic                     z_sat_r;
  logic signed [31:0]       x_ext_s;
  logic signed [31:0]       w_ext_s;
  logic signed [31:0]       prod_s;
  logic                     xfer_s;
  logic                     last_s;
  logic [15:0]              sat_z_s;
  logic                     sat_flag_s;

  assign x_ext_s   = {{16{x_in[15]}}, x_in};
  assign w_ext_s   = {{16{w_in[15]}}, w_in};
  assign prod_s    = x_ext_s * w_ext_s;
  assign acc_sum_s = acc_r + {{(ACC_W-32){prod_s[31]}}, prod_s};
  assign xfer_s    = (state_r == ACCUM) && in_valid;
  assign last_s    = (cnt_r == CNT_LAST);

  q88_sat_narrow #(
    .IN_W (ACC_W)
  ) u_sat (
    .acc   (acc_sum_s),
    .z     (sat_z_s),
    .z_sat (sat_flag_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = ACCUM;
        else       next_state_s = IDLE;
      end
      ACCUM: begin
        if (xfer_s && last_s) next_state_s = OUTPUT;
        else                  next_state_s = ACCUM;
      end
      OUTPUT: begin
        if (z_ready) next_state_s = IDLE;
        else         next_state_s = OUTPUT;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded purely from the state flop.
  always_comb begin
    in_ready = 1'b0;
    z_valid  = 1'b0;
    busy     = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b0;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      OUTPUT: begin
        z_valid = 1'b1;
        busy    = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Accumulator, pair counter and result registers; the bias enters pre-aligned to Q.16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= '0;
      cnt_r   <= '0;
      z_r     <= 16'h0000;
      z_sat_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      acc_r <= {{(ACC_W-24){bias_in[15]}}, bias_in, 8'h00};
      cnt_r <= '0;
    end else if (xfer_s) begin
      acc_r <= acc_sum_s;
      cnt_r <= cnt_r + CNT_W'(1);
      if (last_s) begin
        z_r     <= sat_z_s;
        z_sat_r <= sat_flag_s;
      end
    end
  end

  assign z     = z_r;
  assign z_sat = z_sat_r;

endmodule

// File: tb/tb_neuron_preact_mac.sv
// Self-checking bench for neuron_preact_mac (N_INPUTS = 4): vector table plus
// stall and reset sequences, with a result scoreboard.
module tb_neuron_preact_mac;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bias_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_in;
  logic [15:0] w_in;
  logic        z_valid;
  logic        z_ready;
  logic [15:0] z;
  logic        z_sat;
  logic        busy;

  typedef struct packed {
    logic [15:0]      bias;
    logic [3:0][15:0] x;
    logic [3:0][15:0] w;
    logic [15:0]      z;
    logic             sat;
  } vec_t;

  vec_t        tbl[10];
  logic [16:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  neuron_preact_mac #(.N_INPUTS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bias_in  (bias_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .w_in     (w_in),
    .z_valid  (z_valid),
    .z_ready  (z_ready),
    .z        (z),
    .z_sat    (z_sat),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] b, input logic [15:0] xv, input logic [15:0] wv,
                              input logic [15:0] zz, input logic s);
    vec_t v;
    v.bias = b;
    for (int i = 0; i < 4; i++) begin
      v.x[i] = xv;
      v.w[i] = wv;
    end
    v.z   = zz;
    v.sat = s;
    return v;
  endfunction

  // Scoreboard: every accepted result must match the oldest expectation.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (z_valid && z_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_z", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("z", {16'h0, z}, {16'h0, e[16:1]});
          check("z_sat", {31'h0, z_sat}, {31'h0, e[0]});
        end
      end
    end
  end

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", {31'h0, (exp_q.size() != 0 || busy)}, 32'd0);
  endtask

  task automatic run_neuron(input vec_t v);
    @(negedge clk);
    start   = 1'b1;
    bias_in = v.bias;
    @(negedge clk);
    start = 1'b0;
    check("in_ready_after_start", {31'h0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      x_in     = v.x[i];
      w_in     = v.w[i];
      check("z_valid_early", {31'h0, z_valid}, 32'd0);
      if (i == 3) exp_q.push_back({v.z, v.sat});
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("z_valid_latency", {31'h0, z_valid}, 32'd1);
    wait_drain();
  endtask

  initial begin
    logic [6:0] pat;
    tbl[0] = mk(16'h0000, 16'h0100, 16'h0080, 16'h0200, 1'b0);
    tbl[1] = mk(16'hFF00, 16'h0100, 16'hFF80, 16'hFD00, 1'b0);
    tbl[2] = mk(16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    tbl[3] = mk(16'h0000, 16'h8000, 16'h7FFF, 16'h8000, 1'b1);
    tbl[4] = mk(16'h0000, 16'h0001, 16'h0001, 16'h0000, 1'b0);
    tbl[5] = mk(16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0);
    tbl[6] = mk(16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 1'b0);
    tbl[7] = mk(16'h8000, 16'h0000, 16'h0000, 16'h8000, 1'b0);
    tbl[8] = mk(16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 1'b1);
    tbl[8].x[0] = 16'h0001;
    tbl[8].w[0] = 16'h0100;
    tbl[9] = mk(16'h8000, 16'h0000, 16'h0000, 16'h8000, 1'b1);
    tbl[9].x[0] = 16'hFFFF;
    tbl[9].w[0] = 16'h0100;

    rst_n    = 1'b0;
    start    = 1'b0;
    bias_in  = 16'h0000;
    in_valid = 1'b0;
    x_in     = 16'h0000;
    w_in     = 16'h0000;
    z_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 32'd0);
    check("rst_z_valid", {31'h0, z_valid}, 32'd0);
    check("rst_z", {16'h0, z}, 32'd0);
    check("rst_z_sat", {31'h0, z_sat}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_neuron(tbl[i]);

    // Input stalls with garbage on idle cycles, then a held-off output with start pulses.
    z_ready = 1'b0;
    pat     = 7'b1011001;
    @(negedge clk);
    start   = 1'b1;
    bias_in = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[6-i];
      x_in     = pat[6-i] ? 16'h0100 : 16'h7FFF;
      w_in     = pat[6-i] ? 16'h0080 : 16'h7FFF;
      if (i == 6) begin
        check("stall_z_valid_early", {31'h0, z_valid}, 32'd0);
        exp_q.push_back({16'h0200, 1'b0});
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start   = 1'b1;
      bias_in = 16'h1234;
      check("hold_z_valid", {31'h0, z_valid}, 32'd1);
      check("hold_z", {16'h0, z}, 32'h0200);
      check("hold_in_ready", {31'h0, in_ready}, 32'd0);
      @(negedge clk);
    end
    start   = 1'b0;
    z_ready = 1'b1;
    @(negedge clk);
    check("post_hs_busy", {31'h0, busy}, 32'd0);
    check("post_hs_q", exp_q.size(), 32'd0);
    @(negedge clk);
    check("no_late_start", {31'h0, busy}, 32'd0);
    check("no_late_in_ready", {31'h0, in_ready}, 32'd0);
    run_neuron(tbl[1]);

    // Reset in the middle of accumulation.
    @(negedge clk);
    start   = 1'b1;
    bias_in = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      x_in     = 16'h7FFF;
      w_in     = 16'h7FFF;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'd0);
    check("mid_rst_z_valid", {31'h0, z_valid}, 32'd0);
    check("mid_rst_z", {16'h0, z}, 32'd0);
    check("mid_rst_z_sat", {31'h0, z_sat}, 32'd0);
    check("mid_rst_busy", {31'h0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_neuron(tbl[0]);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
